// File: rtl/knight_pkg.sv
// Shared constants and types for the knight LED chaser family.
// Width and init values are also used by the chaser core.
package knight_pkg;

    localparam int KNIGHT_DIV_WIDTH = 24;

    localparam logic [KNIGHT_DIV_WIDTH-1:0] KNIGHT_DIV_INIT = 24'h7FFFFF;
    localparam logic [KNIGHT_DIV_WIDTH-1:0] KNIGHT_DIV_MIN  = 24'h080000;
    localparam logic [KNIGHT_DIV_WIDTH-1:0] KNIGHT_DIV_MAX  = 24'hF80000;
    localparam logic [KNIGHT_DIV_WIDTH-1:0] KNIGHT_DIV_STEP = 24'h080000;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rpt_state_e;

endpackage

// File: rtl/knight_speed_ctrl_button.sv
// One push-button path: 2-flop sync, debounce, press edge detect
// and optional auto-repeat. Emits a one-cycle evt per press/repeat.
module button_debounce
    import knight_pkg::*;
#(
    parameter int DB_COUNT     = 1_000_000,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk_src,
    input  logic reset_n,
    input  logic btn_raw,
    output logic evt
);

    localparam int DBW = $clog2(DB_COUNT);
    localparam int RW  = (REPEAT_DELAY > REPEAT_RATE) ?
                         $clog2(REPEAT_DELAY) : $clog2(REPEAT_RATE);

    logic           sync1_q, sync2_q;
    logic           acc_q, acc_d;
    logic           acc_dly_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    rpt_state_e     state_q, state_d;
    logic [RW-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic           rise;
    logic           rpt_evt;

    always_comb begin
        acc_d    = acc_q;
        db_cnt_d = '0;
        if (sync2_q != acc_q) begin
            if (db_cnt_q == DBW'(DB_COUNT - 1)) begin
                acc_d = ~acc_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = acc_q & ~acc_dly_q;

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_evt   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = HOLD;
                    rpt_cnt_d = '0;
                end
            end
            HOLD: begin
                if (!acc_q) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RW'(REPEAT_DELAY - 1)) begin
                    state_d   = REPEAT;
                    rpt_cnt_d = '0;
                    rpt_evt   = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!acc_q) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RW'(REPEAT_RATE - 1)) begin
                    rpt_cnt_d = '0;
                    rpt_evt   = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end
        endcase
        if (!REPEAT_EN) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
            rpt_evt   = 1'b0;
        end
    end

    assign evt = rise | rpt_evt;

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            acc_q     <= 1'b0;
            acc_dly_q <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            acc_q     <= acc_d;
            acc_dly_q <= acc_q;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

endmodule

// File: rtl/knight_speed_ctrl.sv
// Button-driven speed control for the LED chaser: turns debounced
// faster/slower/default events into a saturating divider value.
module knight_speed_ctrl
    import knight_pkg::*;
#(
    parameter int DIV_WIDTH    = KNIGHT_DIV_WIDTH,
    parameter int DB_COUNT     = 1_000_000,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter logic [DIV_WIDTH-1:0] DIV_STEP = KNIGHT_DIV_STEP,
    parameter logic [DIV_WIDTH-1:0] DIV_MIN  = KNIGHT_DIV_MIN,
    parameter logic [DIV_WIDTH-1:0] DIV_MAX  = KNIGHT_DIV_MAX,
    parameter logic [DIV_WIDTH-1:0] DIV_INIT = KNIGHT_DIV_INIT
) (
    input  logic                 clk_src,
    input  logic                 reset_n,
    input  logic                 btn_faster,
    input  logic                 btn_slower,
    input  logic                 btn_default,
    output logic [DIV_WIDTH-1:0] divider,
    output logic                 changed
);

    logic                 ev_fast, ev_slow, ev_def;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 changed_q, changed_d;
    logic [DIV_WIDTH:0]   sum, diff;

    button_debounce #(
        .DB_COUNT     (DB_COUNT),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .REPEAT_EN    (1'b1)
    ) u_fast (
        .clk_src (clk_src),
        .reset_n (reset_n),
        .btn_raw (btn_faster),
        .evt     (ev_fast)
    );

    button_debounce #(
        .DB_COUNT     (DB_COUNT),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .REPEAT_EN    (1'b1)
    ) u_slow (
        .clk_src (clk_src),
        .reset_n (reset_n),
        .btn_raw (btn_slower),
        .evt     (ev_slow)
    );

    button_debounce #(
        .DB_COUNT     (DB_COUNT),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .REPEAT_EN    (1'b0)
    ) u_def (
        .clk_src (clk_src),
        .reset_n (reset_n),
        .btn_raw (btn_default),
        .evt     (ev_def)
    );

    // One extra bit so the step can never wrap before the clamp
    always_comb begin
        sum  = {1'b0, div_q} + {1'b0, DIV_STEP};
        diff = {1'b0, div_q} - {1'b0, DIV_STEP};
        div_d = div_q;
        if (ev_def) begin
            div_d = DIV_INIT;
        end else if (ev_fast && ev_slow) begin
            div_d = div_q;
        end else if (ev_fast) begin
            if (diff[DIV_WIDTH] || (diff < {1'b0, DIV_MIN})) begin
                div_d = DIV_MIN;
            end else begin
                div_d = diff[DIV_WIDTH-1:0];
            end
        end else if (ev_slow) begin
            if (sum > {1'b0, DIV_MAX}) begin
                div_d = DIV_MAX;
            end else begin
                div_d = sum[DIV_WIDTH-1:0];
            end
        end
        changed_d = (div_d != div_q);
    end

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= DIV_INIT;
            changed_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            changed_q <= changed_d;
        end
    end

    assign divider = div_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_knight_speed_ctrl.sv
// Scoreboard bench for knight_speed_ctrl with small timing parameters.
// Expected divider updates are queued when buttons are driven.
module tb_knight_speed_ctrl;

    localparam int DB     = 4;
    localparam int RD     = 10;
    localparam int RR     = 3;
    localparam int STEP   = 16;
    localparam int VMIN   = 16;
    localparam int VMAX   = 128;
    localparam int VINIT  = 64;
    localparam int EV_OFS = DB + 2;
    localparam int SETTLE = 12;

    typedef struct {
        int          cyc;
        logic [23:0] div;
        logic        chg;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        btn_faster;
    logic        btn_slower;
    logic        btn_default;
    logic [23:0] divider;
    logic        changed;

    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];
    exp_t mon_e;
    logic [23:0] exp_div;

    knight_speed_ctrl #(
        .DIV_WIDTH    (24),
        .DB_COUNT     (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .DIV_STEP     (24'(STEP)),
        .DIV_MIN      (24'(VMIN)),
        .DIV_MAX      (24'(VMAX)),
        .DIV_INIT     (24'(VINIT))
    ) dut (
        .clk_src     (clk),
        .reset_n     (reset_n),
        .btn_faster  (btn_faster),
        .btn_slower  (btn_slower),
        .btn_default (btn_default),
        .divider     (divider),
        .changed     (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] d,
                                          input logic f, input logic s,
                                          input logic dd);
        int v;
        if (dd) return 24'(VINIT);
        if (f && s) return d;
        if (f) begin
            v = int'(d) - STEP;
            return 24'((v < VMIN) ? VMIN : v);
        end
        if (s) begin
            v = int'(d) + STEP;
            return 24'((v > VMAX) ? VMAX : v);
        end
        return d;
    endfunction

    function automatic bit is_rpt_ev(input int o);
        if (o == EV_OFS) return 1'b1;
        if (o >= EV_OFS + RD && ((o - EV_OFS - RD) % RR) == 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            check("divider", 32'(divider), 32'(mon_e.div));
            check("changed", 32'(changed), 32'(mon_e.chg));
        end else if (changed) begin
            check("spurious_changed", 32'(changed), 32'd0);
        end
    end

    task automatic push_ev(input int at, input logic f, input logic s,
                           input logic d);
        logic [23:0] nd;
        nd = model(exp_div, f, s, d);
        sb.push_back('{cyc: at, div: nd, chg: (nd != exp_div)});
        exp_div = nd;
    endtask

    task automatic hold(input logic f, input logic s, input logic d,
                        input int n);
        int  k;
        bit  ef, es, ed;
        @(negedge clk);
        k = cyc;
        btn_faster  = f;
        btn_slower  = s;
        btn_default = d;
        for (int o = EV_OFS; o <= n + EV_OFS - 1; o++) begin
            ef = f && is_rpt_ev(o);
            es = s && is_rpt_ev(o);
            ed = d && (o == EV_OFS);
            if (ef || es || ed) push_ev(k + o + 1, ef, es, ed);
        end
        repeat (n) @(negedge clk);
        btn_faster  = 1'b0;
        btn_slower  = 1'b0;
        btn_default = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    initial begin
        int k;
        cyc = 0;
        tests = 0;
        fails = 0;
        exp_div = 24'(VINIT);
        reset_n = 1'b0;
        btn_faster = 1'b0;
        btn_slower = 1'b0;
        btn_default = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_divider", 32'(divider), VINIT);
        check("rst_changed", 32'(changed), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // bounce: 3 high, 1 low, 2 high never survives debounce
        btn_faster = 1'b1;
        repeat (3) @(negedge clk);
        btn_faster = 1'b0;
        @(negedge clk);
        btn_faster = 1'b1;
        repeat (2) @(negedge clk);
        btn_faster = 1'b0;
        repeat (15) @(negedge clk);
        check("bounce_divider", 32'(divider), VINIT);

        hold(1'b1, 1'b0, 1'b0, 40);
        check("fast_floor", 32'(divider), VMIN);

        // reset during a slower hold, button kept down across reset
        @(negedge clk);
        k = cyc;
        btn_slower = 1'b1;
        push_ev(k + EV_OFS + 1, 1'b0, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_divider", 32'(divider), VINIT);
        check("midrst_changed", 32'(changed), 32'd0);
        exp_div = 24'(VINIT);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        k = cyc;
        push_ev(k + EV_OFS + 1, 1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        btn_slower = 1'b0;
        repeat (SETTLE) @(negedge clk);

        hold(1'b0, 1'b0, 1'b1, 8);
        hold(1'b0, 1'b1, 1'b0, 8);
        hold(1'b0, 1'b1, 1'b0, 8);
        hold(1'b0, 1'b1, 1'b0, 8);
        check("three_taps", 32'(divider), 112);
        hold(1'b0, 1'b0, 1'b1, 50);
        hold(1'b0, 1'b0, 1'b1, 8);
        hold(1'b0, 1'b1, 1'b0, 30);
        check("slow_ceiling", 32'(divider), VMAX);
        hold(1'b1, 1'b1, 1'b0, 8);
        hold(1'b1, 1'b1, 1'b1, 8);
        check("final_divider", 32'(divider), VINIT);
        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
